spi_shift_engine: RTL and testbench

Parametrised full-duplex SPI shift engine for the SPI master datapath. It transmits and receives one frame of programmable length, 1..N bits, MSB-first or LSB-first. A frame starts on a single-cycle handshake and ends with a done pulse. Bit timing comes from external launch/sample strobes issued by the SCLK generator, so any CPOL/CPHA mode can be built on top.

---
 rtl/spi_shift_engine_pkg.sv | 19 +
 rtl/spi_shift_engine.sv | 125 ++++++++++++
 tb/tb_spi_shift_engine.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_shift_engine_pkg.sv
// Shared types and constants for the SPI shift engine: FSM states, bit-order
// encodings and the frame-length field width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  // Width of the frame_len field (frame length minus one) for an n-bit engine.
  function automatic int len_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine: one frame of 1..N bits, MSB- or LSB-first,
// timed by external launch/sample strobes from the SCLK generator.
//
// state | meaning
// IDLE  | waiting for start; sout held low
// SHIFT | frame in progress; strobes drive sout and capture sin
// DONE  | single-cycle end of frame; done=1, rx_data just updated
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter  int N     = 32,
  localparam int LEN_W = len_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     tx_data,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             lsb_first,
  input  logic             launch_en,
  input  logic             sample_en,
  input  logic             sin,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     rx_data
);

  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [N-1:0]     tx_q;
  logic [N-1:0]     rx_sh;
  logic [N-1:0]     rx_nxt;
  logic [LEN_W-1:0] len_q;
  logic             lsb_q;
  logic [LEN_W:0]   rx_cnt;
  logic [LEN_W:0]   rx_cnt_inc;
  logic [LEN_W:0]   tx_cnt;
  logic [LEN_W:0]   len_full;
  logic [LEN_W-1:0] rx_idx;
  logic [LEN_W-1:0] tx_idx;
  logic             accept;
  logic             do_sample;
  logic             do_launch;
  logic             last_sample;
  logic             tx_more;

  assign accept      = (state == IDLE) && start;
  assign do_sample   = (state == SHIFT) && sample_en;
  assign do_launch   = (state == SHIFT) && launch_en;
  assign len_full    = {1'b0, len_q} + CNT_ONE;
  assign rx_cnt_inc  = rx_cnt + CNT_ONE;
  assign last_sample = do_sample && (rx_cnt_inc == len_full);
  // tx_cnt counts bits already driven onto sout, so launches past the last bit stall.
  assign tx_more     = tx_cnt < len_full;

  // Bit positions are mirrored for MSB-first so both orders land right-justified.
  assign rx_idx = lsb_q ? rx_cnt[LEN_W-1:0] : (len_q - rx_cnt[LEN_W-1:0]);
  assign tx_idx = lsb_q ? tx_cnt[LEN_W-1:0] : (len_q - tx_cnt[LEN_W-1:0]);

  always_comb begin
    rx_nxt = rx_sh;
    if (do_sample) begin
      rx_nxt[rx_idx] = sin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_sample) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q    <= '0;
      rx_sh   <= '0;
      len_q   <= '0;
      lsb_q   <= MSB_FIRST;
      rx_cnt  <= '0;
      tx_cnt  <= '0;
      sout    <= 1'b0;
      rx_data <= '0;
    end else if (accept) begin
      tx_q   <= tx_data;
      len_q  <= frame_len;
      lsb_q  <= lsb_first;
      rx_sh  <= '0;
      rx_cnt <= '0;
      tx_cnt <= CNT_ONE;
      sout   <= (lsb_first == LSB_FIRST) ? tx_data[0] : tx_data[frame_len];
    end else if (state == SHIFT) begin
      if (do_sample) begin
        rx_sh  <= rx_nxt;
        rx_cnt <= rx_cnt_inc;
      end
      if (do_launch && tx_more) begin
        sout   <= tx_q[tx_idx];
        tx_cnt <= tx_cnt + CNT_ONE;
      end
      if (last_sample) begin
        rx_data <= rx_nxt;
      end
    end else if (state == DONE) begin
      sout <= 1'b0;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine (N=8): table vectors, random frames
// against a bit-list reference model, plus restart and reset-abort sequences.
module tb_spi_shift_engine;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic [2:0] frame_len;
  logic       lsb_first;
  logic       launch_en;
  logic       sample_en;
  logic       sin;
  logic       sout;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_rx = 8'h00;

  always #5 clk = ~clk;

  spi_shift_engine #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tx_data   (tx_data),
    .frame_len (frame_len),
    .lsb_first (lsb_first),
    .launch_en (launch_en),
    .sample_en (sample_en),
    .sin       (sin),
    .sout      (sout),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data)
  );

  typedef struct {
    logic [7:0] tx;
    int         len;
    logic       lsb;
    int         sin_mode;     // 0 loopback, 1 tied 1, 2 pattern, 3 tied 0, 4 random
    logic [7:0] pat;          // pattern bits, first received bit at pat[L-1]
    int         strobe_mode;  // 0 alternate sample/launch, 1 random, 2 both every cycle
    bit         restart;      // pulse start with junk data while busy
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // k-th transmitted bit of a frame, counted from the first bit on the wire.
  function automatic logic txbit(input logic [7:0] tx, input int len, input logic lsb, input int k);
    return lsb ? tx[k] : tx[len-k];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] tx, input int len, input logic lsb,
                           input int sin_mode, input logic [7:0] pat,
                           input int strobe_mode, input bit restart,
                           output logic [7:0] got);
    int         nbits;
    int         d;
    int         s;
    int         c;
    bit         fin;
    logic       l;
    logic       sm;
    logic       sv;
    logic [7:0] exp_rx;
    nbits  = len + 1;
    d      = 1;
    s      = 0;
    c      = 0;
    fin    = 0;
    exp_rx = 8'h00;
    got    = 8'h00;
    start = 1'b1; tx_data = tx; frame_len = len[2:0]; lsb_first = lsb;
    launch_en = 1'b0; sample_en = 1'b0;
    step();
    start = 1'b0; tx_data = ~tx; frame_len = 3'($urandom); lsb_first = ~lsb;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_done", 32'(done), 32'd0);
    chk("first_bit", 32'(sout), 32'(txbit(tx, len, lsb, 0)));
    while (!fin && c < 200) begin
      case (strobe_mode)
        0:       begin sm = (c % 2 == 0); l = (c % 2 == 1); end
        1:       begin l = 1'($urandom % 2); sm = ($urandom % 3 == 0); end
        default: begin l = 1'b1; sm = 1'b1; end
      endcase
      case (sin_mode)
        0:       sv = txbit(tx, len, lsb, d - 1);
        1:       sv = 1'b1;
        2:       sv = pat[nbits-1-s];
        3:       sv = 1'b0;
        default: sv = 1'($urandom % 2);
      endcase
      launch_en = l; sample_en = sm; sin = sv;
      if (restart) begin
        start = 1'($urandom % 2);
        tx_data = 8'($urandom);
        frame_len = 3'($urandom);
        lsb_first = 1'($urandom % 2);
      end
      if (sm) begin
        exp_rx[lsb ? s : nbits-1-s] = sv;
        s++;
      end
      if (l && d < nbits) d++;
      step();
      c++;
      if (s == nbits) begin
        fin = 1;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_rx", 32'(rx_data), 32'(exp_rx));
        got = rx_data;
      end else begin
        chk("shift_done_low", 32'(done), 32'd0);
        chk("shift_busy", 32'(busy), 32'd1);
        chk("sout_bit", 32'(sout), 32'(txbit(tx, len, lsb, d - 1)));
        chk("rx_hold", 32'(rx_data), 32'(last_rx));
      end
    end
    if (!fin) chk("frame_timeout", 32'(s), 32'(nbits));
    // start during the DONE cycle must be ignored
    launch_en = 1'b1; sample_en = 1'b1; start = 1'b1; tx_data = 8'hFF; frame_len = 3'd7;
    step();
    start = 1'b0; launch_en = 1'b0; sample_en = 1'b0;
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_done", 32'(done), 32'd0);
    chk("post_sout", 32'(sout), 32'd0);
    chk("post_rx", 32'(rx_data), 32'(exp_rx));
    last_rx = exp_rx;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    int         samples;
    bit         saw_done;

    vecs[0] = '{tx: 8'hA5, len: 7, lsb: 1'b0, sin_mode: 0, pat: 8'h00, strobe_mode: 0, restart: 0, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'h01, len: 7, lsb: 1'b1, sin_mode: 1, pat: 8'h00, strobe_mode: 0, restart: 0, exp_rx: 8'hFF};
    vecs[2] = '{tx: 8'hFC, len: 3, lsb: 1'b0, sin_mode: 2, pat: 8'h09, strobe_mode: 0, restart: 0, exp_rx: 8'h09};
    vecs[3] = '{tx: 8'h01, len: 0, lsb: 1'b0, sin_mode: 3, pat: 8'h00, strobe_mode: 0, restart: 0, exp_rx: 8'h00};
    vecs[4] = '{tx: 8'h5A, len: 7, lsb: 1'b1, sin_mode: 0, pat: 8'h00, strobe_mode: 2, restart: 0, exp_rx: 8'h5A};
    vecs[5] = '{tx: 8'hC3, len: 7, lsb: 1'b0, sin_mode: 0, pat: 8'h00, strobe_mode: 2, restart: 1, exp_rx: 8'hC3};

    rst = 1'b1; start = 1'b0; tx_data = 8'h00; frame_len = 3'd0; lsb_first = 1'b0;
    launch_en = 1'b0; sample_en = 1'b0; sin = 1'b0;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sout", 32'(sout), 32'd0);
    chk("reset_rx", 32'(rx_data), 32'd0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_frame(vecs[i].tx, vecs[i].len, vecs[i].lsb, vecs[i].sin_mode, vecs[i].pat,
                vecs[i].strobe_mode, vecs[i].restart, got);
      chk($sformatf("vec%0d_rx", i), 32'(got), 32'(vecs[i].exp_rx));
    end

    for (int f = 0; f < 30; f++) begin
      run_frame(8'($urandom), int'($urandom_range(0, 7)), 1'($urandom % 2), 4, 8'h00,
                (f % 3 == 2) ? 2 : 1, bit'($urandom % 2), got);
    end

    // Reset abort after the 3rd sample of an 8-bit MSB-first frame of 0x3C.
    run_frame(8'h81, 7, 1'b0, 0, 8'h00, 0, 0, got);
    start = 1'b1; tx_data = 8'h3C; frame_len = 3'd7; lsb_first = 1'b0;
    step();
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sample_en = (c % 2 == 0); launch_en = (c % 2 == 1); sin = 1'b1;
      step();
    end
    launch_en = 1'b0; sample_en = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_sout", 32'(sout), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sout", 32'(sout), 32'd0);
    chk("abort_rx", 32'(rx_data), 32'd0);
    saw_done = 0;
    samples = 0;
    for (int c = 0; c < 8; c++) begin
      sample_en = 1'b1; launch_en = 1'b1;
      if (c == 3) rst = 1'b0;
      step();
      if (done) saw_done = 1;
      samples++;
    end
    sample_en = 1'b0; launch_en = 1'b0;
    chk("abort_no_done", 32'(saw_done), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    last_rx = 8'h00;
    run_frame(8'h3C, 7, 1'b0, 0, 8'h00, 0, 0, got);
    chk("after_abort_rx", 32'(got), 32'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
